// File: rtl/rename_regfile_mp.sv
// Rename register file: arch->phys map, phys data, busy bits, lowest-index free list, old-name table.
// Define RENAME_WB_BYPASS_EN to forward same-cycle writeback data/busy onto the read ports.
module rename_regfile_mp #(
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int name_width = 6,
    parameter int NUM_ARCH   = 32,
    parameter int NUM_PHYS   = 64,
    parameter int NUM_RD     = 2
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [addr_width-1:0]          ADDR_IN,
    input  logic                           ALLOC_E,
    output logic                           ALLOC_READY,
    output logic [name_width-1:0]          NAME_OUT,
    output logic [name_width:0]            FREE_CNT,
    input  logic [NUM_RD*addr_width-1:0]   ADDR_RD,
    output logic [NUM_RD*name_width-1:0]   NAME_RD,
    input  logic [NUM_RD*name_width-1:0]   NAME_DRD,
    output logic [NUM_RD*data_width-1:0]   D_OUT,
    input  logic [NUM_RD*name_width-1:0]   BUSY_NAME,
    output logic [NUM_RD-1:0]              BUSY_OUT,
    input  logic [name_width-1:0]          NAME_W,
    input  logic [data_width-1:0]          D_IN,
    input  logic                           WE,
    input  logic [name_width-1:0]          NAME_F,
    input  logic                           FE
);

    logic [name_width-1:0] r_names [NUM_ARCH];
    logic [data_width-1:0] r_phys  [NUM_PHYS];
    logic [name_width-1:0] r_old   [NUM_PHYS];
    logic [NUM_PHYS-1:0]   r_busy;
    logic [NUM_PHYS-1:0]   r_free;

    logic [name_width-1:0] w_alloc_name;
    logic [name_width:0]   w_free_cnt;
    logic                  w_alloc_ready;
    logic                  w_alloc_fire;
    logic [name_width-1:0] w_prev_name;
    logic [name_width-1:0] w_freed_name;
    logic [NUM_PHYS-1:0]   w_alloc_mask;
    logic [NUM_PHYS-1:0]   w_wb_mask;
    logic [NUM_PHYS-1:0]   w_fe_mask;

    // NOTE: always_comb outputs get a default before the loop so no path leaves them unassigned (no latch).
    always_comb begin
        w_alloc_name = '0;
        for (int i = NUM_PHYS - 1; i >= 0; i--) begin
            if (r_free[i]) begin
                w_alloc_name = name_width'(i);
            end
        end
    end

    always_comb begin
        w_free_cnt = '0;
        for (int i = 0; i < NUM_PHYS; i++) begin
            w_free_cnt = w_free_cnt + (name_width + 1)'(r_free[i]);
        end
    end

    assign w_alloc_ready = |r_free;
    assign w_alloc_fire  = ALLOC_E && w_alloc_ready;
    assign w_prev_name   = r_names[ADDR_IN];
    assign w_freed_name  = r_old[NAME_F];

    assign ALLOC_READY = w_alloc_ready;
    assign NAME_OUT    = w_alloc_name;
    assign FREE_CNT    = w_free_cnt;

    // One-hot update masks, all derived from pre-edge state; the alloc mask is applied last so it wins.
    assign w_alloc_mask = w_alloc_fire ? (NUM_PHYS'(1) << w_alloc_name) : '0;
    assign w_wb_mask    = WE           ? (NUM_PHYS'(1) << NAME_W)       : '0;
    assign w_fe_mask    = FE           ? (NUM_PHYS'(1) << w_freed_name) : '0;

    // NOTE: sequential state uses non-blocking assignments so every block sees the pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                r_free[i] <= (i >= NUM_ARCH);
            end
            r_busy <= '0;
        end else begin
            r_free <= (r_free | w_fe_mask) & ~w_alloc_mask;
            r_busy <= (r_busy & ~w_wb_mask) | w_alloc_mask;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                r_names[i] <= name_width'(i);
            end
        end else if (w_alloc_fire) begin
            r_names[ADDR_IN] <= w_alloc_name;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                r_old[i] <= '0;
            end
        end else if (w_alloc_fire) begin
            r_old[w_alloc_name] <= w_prev_name;
        end
    end

    // NOTE: the data array is reset on purpose: D_OUT must read 0 for every name after reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                r_phys[i] <= '0;
            end
        end else if (WE) begin
            r_phys[NAME_W] <= D_IN;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [addr_width-1:0] w_addr;
        logic [name_width-1:0] w_dname;
        logic [name_width-1:0] w_bname;

        assign w_addr  = ADDR_RD[k*addr_width +: addr_width];
        assign w_dname = NAME_DRD[k*name_width +: name_width];
        assign w_bname = BUSY_NAME[k*name_width +: name_width];

        assign NAME_RD[k*name_width +: name_width] = r_names[w_addr];
`ifdef RENAME_WB_BYPASS_EN
        assign D_OUT[k*data_width +: data_width] = (WE && (w_dname == NAME_W)) ? D_IN : r_phys[w_dname];
        assign BUSY_OUT[k] = (WE && (w_bname == NAME_W)) ? 1'b0 : r_busy[w_bname];
`else
        assign D_OUT[k*data_width +: data_width] = r_phys[w_dname];
        assign BUSY_OUT[k] = r_busy[w_bname];
`endif
    end

endmodule
